// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - one-hot machine-cycle phase generator with run/step control
module phase_sequencer #(
  parameter int NUM_PHASES = 4,
  parameter int DIV        = 1,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  input  logic                          step,
  output logic [0:NUM_PHASES-1]         phase,
  output logic [$clog2(NUM_PHASES)-1:0] stage,
  output logic                          phase_start,
  output logic                          cycle_end,
  output logic [CNT_W-1:0]              cycle_count,
  output logic                          halted
);

  localparam int STAGE_W = $clog2(NUM_PHASES);
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] S_HALTED = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_STEP   = 2'd2;

  localparam logic [0:NUM_PHASES-1] FIRST_PHASE = {1'b1, {(NUM_PHASES-1){1'b0}}};

  logic [1:0]            r_state;
  logic [0:NUM_PHASES-1] r_phase;
  logic [STAGE_W-1:0]    r_stage;
  logic [DIV_W-1:0]      r_div;
  logic [CNT_W-1:0]      r_count;

  logic w_halted;
  logic w_div_last;
  logic w_stage_last;

  assign w_halted     = (r_state == S_HALTED);
  assign w_div_last   = (r_div == DIV_W'(DIV - 1));
  assign w_stage_last = (r_stage == STAGE_W'(NUM_PHASES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HALTED;
      r_phase <= '0;
      r_stage <= '0;
      r_div   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_HALTED: begin
          if (run || step) begin
            r_state <= run ? S_RUN : S_STEP;
            r_phase <= FIRST_PHASE;
            r_stage <= '0;
            r_div   <= '0;
          end
        end
        S_RUN, S_STEP: begin
          if (w_div_last) begin
            r_div <= '0;
            if (w_stage_last) begin
              // Cycle boundary: run alone decides whether another cycle follows.
              r_count <= r_count + CNT_W'(1);
              r_stage <= '0;
              if (run) begin
                r_state <= S_RUN;
                r_phase <= FIRST_PHASE;
              end else begin
                r_state <= S_HALTED;
                r_phase <= '0;
              end
            end else begin
              r_stage <= r_stage + STAGE_W'(1);
              r_phase <= r_phase >> 1;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        default: begin
          r_state <= S_HALTED;
          r_phase <= '0;
          r_stage <= '0;
          r_div   <= '0;
        end
      endcase
    end
  end

  assign phase       = r_phase;
  assign stage       = r_stage;
  assign halted      = w_halted;
  assign cycle_count = r_count;
  assign phase_start = !w_halted && (r_div == '0);
  assign cycle_end   = !w_halted && w_stage_last && w_div_last;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - directed vector bench for phase_sequencer
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default instance (4 phases, DIV=1, 16-bit count)
  logic        run0 = 1'b0, step0 = 1'b0;
  logic [0:3]  phase0;
  logic [1:0]  stage0;
  logic        ps0, ce0, hl0;
  logic [15:0] cnt0;

  // Divided instance (DIV=5)
  logic        run1 = 1'b0;
  logic [0:3]  phase1;
  logic [1:0]  stage1;
  logic        ps1, ce1, hl1;
  logic [15:0] cnt1;

  // Three-phase instance with 2-bit counter
  logic        run2 = 1'b0;
  logic [0:2]  phase2;
  logic [1:0]  stage2;
  logic        ps2, ce2, hl2;
  logic [1:0]  cnt2;

  phase_sequencer u_dut0 (
    .clk(clk), .rst_n(rst_n), .run(run0), .step(step0),
    .phase(phase0), .stage(stage0), .phase_start(ps0), .cycle_end(ce0),
    .cycle_count(cnt0), .halted(hl0)
  );

  phase_sequencer #(.NUM_PHASES(4), .DIV(5), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .run(run1), .step(1'b0),
    .phase(phase1), .stage(stage1), .phase_start(ps1), .cycle_end(ce1),
    .cycle_count(cnt1), .halted(hl1)
  );

  phase_sequencer #(.NUM_PHASES(3), .DIV(1), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .run(run2), .step(1'b0),
    .phase(phase2), .stage(stage2), .phase_start(ps2), .cycle_end(ce2),
    .cycle_count(cnt2), .halted(hl2)
  );

  typedef struct {
    logic        run;
    logic        step;
    logic [3:0]  ph;
    logic [1:0]  st;
    logic        ps;
    logic        ce;
    logic [15:0] cnt;
    logic        hl;
  } vec_t;

  vec_t vecs[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic r, input logic s, input logic [3:0] ph,
                              input logic [1:0] st, input logic ps, input logic ce,
                              input logic [15:0] cnt, input logic hl);
    vec_t v;
    v.run = r; v.step = s; v.ph = ph; v.st = st;
    v.ps = ps; v.ce = ce; v.cnt = cnt; v.hl = hl;
    vecs.push_back(v);
  endfunction

  task automatic chk0(input string tag, input logic [3:0] ph, input logic [1:0] st,
                      input logic ps, input logic ce, input logic [15:0] cnt, input logic hl);
    chk({tag, ".phase"}, 32'(phase0), 32'(ph));
    chk({tag, ".stage"}, 32'(stage0), 32'(st));
    chk({tag, ".phase_start"}, 32'(ps0), 32'(ps));
    chk({tag, ".cycle_end"}, 32'(ce0), 32'(ce));
    chk({tag, ".cycle_count"}, 32'(cnt0), 32'(cnt));
    chk({tag, ".halted"}, 32'(hl0), 32'(hl));
  endtask

  initial begin
    int ps_seen;
    // run  step  phase    st  ps ce cnt hl
    add(1, 0, 4'b1000, 0, 1, 0, 0, 0);
    add(1, 0, 4'b0100, 1, 1, 0, 0, 0);
    add(1, 0, 4'b0010, 2, 1, 0, 0, 0);
    add(1, 0, 4'b0001, 3, 1, 1, 0, 0);
    add(1, 0, 4'b1000, 0, 1, 0, 1, 0);
    add(1, 0, 4'b0100, 1, 1, 0, 1, 0);
    add(0, 0, 4'b0010, 2, 1, 0, 1, 0);  // run dropped during stage 1
    add(0, 0, 4'b0001, 3, 1, 1, 1, 0);
    add(0, 0, 4'b0000, 0, 0, 0, 2, 1);
    add(0, 0, 4'b0000, 0, 0, 0, 2, 1);
    add(0, 1, 4'b1000, 0, 1, 0, 2, 0);  // single step
    add(0, 1, 4'b0100, 1, 1, 0, 2, 0);  // second pulse mid-cycle
    add(0, 0, 4'b0010, 2, 1, 0, 2, 0);
    add(0, 0, 4'b0001, 3, 1, 1, 2, 0);
    add(0, 0, 4'b0000, 0, 0, 0, 3, 1);
    add(0, 0, 4'b0000, 0, 0, 0, 3, 1);  // no queued step
    add(1, 1, 4'b1000, 0, 1, 0, 3, 0);
    add(0, 0, 4'b0100, 1, 1, 0, 3, 0);
    add(0, 0, 4'b0010, 2, 1, 0, 3, 0);
    add(0, 0, 4'b0001, 3, 1, 1, 3, 0);
    add(0, 0, 4'b0000, 0, 0, 0, 4, 1);
    add(0, 1, 4'b1000, 0, 1, 0, 4, 0);  // STEP, then run raised
    add(1, 0, 4'b0100, 1, 1, 0, 4, 0);
    add(1, 0, 4'b0010, 2, 1, 0, 4, 0);
    add(1, 0, 4'b0001, 3, 1, 1, 4, 0);
    add(1, 0, 4'b1000, 0, 1, 0, 5, 0);
    add(1, 0, 4'b0100, 1, 1, 0, 5, 0);
    add(0, 0, 4'b0010, 2, 1, 0, 5, 0);
    add(0, 0, 4'b0001, 3, 1, 1, 5, 0);
    add(0, 0, 4'b0000, 0, 0, 0, 6, 1);

    #2;
    chk0("reset", 4'b0000, 0, 0, 0, 0, 1);
    tick();
    chk0("idle", 4'b0000, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    tick();
    chk0("post_reset_idle", 4'b0000, 0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      run0  = vecs[i].run;
      step0 = vecs[i].step;
      tick();
      chk0($sformatf("vec%0d", i), vecs[i].ph, vecs[i].st, vecs[i].ps,
           vecs[i].ce, vecs[i].cnt, vecs[i].hl);
    end
    run0 = 1'b0; step0 = 1'b0;

    // DIV=5: after edge n (n>=1) the position is k=n-1 clocks into the run
    run1 = 1'b1;
    ps_seen = 0;
    for (int n = 1; n <= 41; n++) begin
      int k;
      tick();
      k = n - 1;
      if (n <= 40 && ps1) ps_seen++;
      chk($sformatf("div5.stage[%0d]", n), 32'(stage1), 32'((k / 5) % 4));
      chk($sformatf("div5.phase[%0d]", n), 32'(phase1), 32'(4'b1000 >> ((k / 5) % 4)));
      chk($sformatf("div5.phase_start[%0d]", n), 32'(ps1), 32'((k % 5) == 0));
      chk($sformatf("div5.cycle_end[%0d]", n), 32'(ce1), 32'(((k % 20) == 19)));
      chk($sformatf("div5.cycle_count[%0d]", n), 32'(cnt1), 32'(k / 20));
    end
    chk("div5.phase_start_total", 32'(ps_seen), 32'd8);
    chk("div5.count_after_40", 32'(cnt1), 32'd2);
    run1 = 1'b0;

    // Three phases, 2-bit counter wraps 1,2,3,0,1
    run2 = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      int k;
      tick();
      k = n - 1;
      chk($sformatf("np3.stage[%0d]", n), 32'(stage2), 32'(k % 3));
      chk($sformatf("np3.phase[%0d]", n), 32'(phase2), 32'(3'b100 >> (k % 3)));
      chk($sformatf("np3.cycle_end[%0d]", n), 32'(ce2), 32'((k % 3) == 2));
      chk($sformatf("np3.cycle_count[%0d]", n), 32'(cnt2), 32'((k / 3) % 4));
    end
    run2 = 1'b0;

    // Asynchronous reset in stage 2, checked between clock edges
    run0 = 1'b1;
    tick(); tick(); tick();
    chk0("pre_reset_stage2", 4'b0010, 2, 1, 0, 6, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk0("async_reset", 4'b0000, 0, 0, 0, 0, 1);
    run0 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk0("released_idle", 4'b0000, 0, 0, 0, 0, 1);
    run0 = 1'b1;
    tick();
    chk0("first_after_reset", 4'b1000, 0, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
